pc_hazard_ctrl: RTL and testbench

Fetch-sequencing controller for the pipelined CPU's program counter and the IF/ID and ID/EX pipeline registers. It produces the PC's reset, select (`pc_src`), stall (`pc_delay`) and redirect-target controls. It detects load-use hazards, absorbs instruction-memory wait states, defers branch redirects that resolve during a memory wait, and handles halt. It sits beside the PC register in IF and consumes decode/execute-stage hazard information.

---
 rtl/pc_hazard_ctrl.sv | 175 +++++++++++++++++
 tb/tb_pc_hazard_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pc_hazard_ctrl.sv
// Fetch-sequencing controller: drives PC reset/select/stall/redirect and the
// IF/ID and ID/EX hold/flush/bubble controls for load-use, imem waits and halt.
module pc_hazard_ctrl #(
  parameter int BOOT_CYCLES = 2,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             imem_ready,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rt,
  input  logic             ex_branch_taken,
  input  logic [31:0]      ex_target,
  input  logic             halt_req,
  output logic             pc_reset,
  output logic             pc_src,
  output logic [31:0]      pc_target,
  output logic             pc_delay,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [1:0]       state_dbg
);

  // Handshake: none. All outputs are combinational from state and inputs and
  // are sampled by the PC / pipeline registers on the next rising edge.

  localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);

  typedef enum logic [1:0] {
    BOOT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2,
    HALT     = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [BW-1:0] boot_cnt;
  logic          pend;
  logic [31:0]   pend_target;
  logic          pend_set;
  logic          pend_clr;
  logic          stall_inc;
  logic          redir_inc;
  logic          lu;

  assign lu = ex_memread & (ex_rt != 5'd0) &
              ((id_uses_rs & (id_rs == ex_rt)) | (id_uses_rt & (id_rt == ex_rt)));

  assign state_dbg = state;

  always_comb begin
    state_nx    = state;
    pc_reset    = 1'b0;
    pc_src      = 1'b0;
    pc_target   = 32'd0;
    pc_delay    = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    halted      = 1'b0;
    pend_set    = 1'b0;
    pend_clr    = 1'b0;
    stall_inc   = 1'b0;
    redir_inc   = 1'b0;
    case (state)
      BOOT: begin
        pc_reset    = 1'b1;
        pc_delay    = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        if (boot_cnt == BOOT_LAST) state_nx = RUN;
      end
      RUN: begin
        // A taken branch outranks everything: the ID instruction is wrong-path.
        if (ex_branch_taken) begin
          pc_src      = 1'b1;
          pc_target   = ex_target;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          redir_inc   = 1'b1;
        end else if (halt_req) begin
          pc_delay    = 1'b1;
          ifid_hold   = 1'b1;
          idex_bubble = 1'b1;
          state_nx    = HALT;
        end else if (lu) begin
          pc_delay    = 1'b1;
          ifid_hold   = 1'b1;
          idex_bubble = 1'b1;
          stall_inc   = 1'b1;
        end else if (!imem_ready) begin
          pc_delay    = 1'b1;
          ifid_flush  = 1'b1;
          state_nx    = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        pc_delay   = 1'b1;
        ifid_flush = 1'b1;
        stall_inc  = 1'b1;
        if (ex_branch_taken && !pend) begin
          idex_bubble = 1'b1;
          if (!imem_ready) pend_set = 1'b1;
        end
        if (lu) begin
          ifid_hold   = 1'b1;
          ifid_flush  = 1'b0;
          idex_bubble = 1'b1;
        end
        if (imem_ready) begin
          state_nx = RUN;
          pc_delay = 1'b0;
          // A deferred redirect beats a branch arriving on the same cycle.
          if (pend) begin
            pc_src     = 1'b1;
            pc_target  = pend_target;
            ifid_flush = 1'b1;
            ifid_hold  = 1'b0;
            pend_clr   = 1'b1;
            redir_inc  = 1'b1;
          end else if (ex_branch_taken) begin
            pc_src     = 1'b1;
            pc_target  = ex_target;
            ifid_flush = 1'b1;
            ifid_hold  = 1'b0;
            redir_inc  = 1'b1;
          end else begin
            ifid_flush = 1'b0;
          end
        end
      end
      HALT: begin
        pc_delay    = 1'b1;
        ifid_hold   = 1'b1;
        idex_bubble = 1'b1;
        halted      = 1'b1;
      end
      default: state_nx = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= BOOT;
      boot_cnt     <= '0;
      pend         <= 1'b0;
      pend_target  <= 32'd0;
      stall_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == BOOT && boot_cnt != BOOT_LAST) boot_cnt <= boot_cnt + BW'(1);
      if (pend_set) begin
        pend        <= 1'b1;
        pend_target <= ex_target;
      end else if (pend_clr) begin
        pend <= 1'b0;
      end
      // Counters saturate at all-ones.
      if (stall_inc && stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + CNT_W'(1);
      if (redir_inc && redirect_cnt != {CNT_W{1'b1}}) redirect_cnt <= redirect_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pc_hazard_ctrl.sv
// Directed bench for pc_hazard_ctrl: each driven cycle queues its expected
// output vector; a negedge monitor pops and compares it.
module tb_pc_hazard_ctrl;

  localparam int W = 49;
  localparam logic [1:0] S_BOOT = 2'd0, S_RUN = 2'd1, S_MW = 2'd2, S_HALT = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_ready;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rs, id_uses_rt, ex_memread, ex_branch_taken, halt_req;
  logic [31:0] ex_target;
  logic        pc_reset, pc_src, pc_delay, ifid_hold, ifid_flush, idex_bubble, halted;
  logic [31:0] pc_target;
  logic [3:0]  stall_cnt, redirect_cnt;
  logic [1:0]  state_dbg;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           errors = 0;
  int           checks = 0;
  logic [W-1:0] act;

  always #5 clk = ~clk;

  pc_hazard_ctrl #(.BOOT_CYCLES(2), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .imem_ready(imem_ready),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .ex_branch_taken(ex_branch_taken),
    .ex_target(ex_target), .halt_req(halt_req),
    .pc_reset(pc_reset), .pc_src(pc_src), .pc_target(pc_target), .pc_delay(pc_delay),
    .ifid_hold(ifid_hold), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .halted(halted), .stall_cnt(stall_cnt), .redirect_cnt(redirect_cnt),
    .state_dbg(state_dbg)
  );

  assign act = {pc_reset, pc_src, pc_target, pc_delay, ifid_hold, ifid_flush,
                idex_bubble, halted, stall_cnt, redirect_cnt, state_dbg};

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", n, act, e);
      end
    end
  end

  task automatic idle();
    reset = 1'b1; imem_ready = 1'b1;
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    ex_memread = 1'b0; ex_rt = 5'd0; ex_branch_taken = 1'b0;
    ex_target = 32'd0; halt_req = 1'b0;
  endtask

  task automatic set_lu();
    ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
  endtask

  task automatic cyc(input string n, input logic prst, src, input logic [31:0] tgt,
                     input logic dly, hold, flush, bub, hlt,
                     input logic [3:0] sc, rc, input logic [1:0] st);
    exp_q.push_back({prst, src, tgt, dly, hold, flush, bub, hlt, sc, rc, st});
    name_q.push_back(n);
    @(posedge clk); #1;
    idle();
  endtask

  task automatic boot_cyc(input string n);
    cyc(n, 1, 0, 32'd0, 1, 0, 1, 1, 0, 4'd0, 4'd0, S_BOOT);
  endtask

  initial begin
    int sc_exp;
    idle();
    reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin reset = 1'b0; boot_cyc("reset"); end
    boot_cyc("boot1");
    boot_cyc("boot2");
    cyc("run_idle", 0, 0, 32'd0, 0, 0, 0, 0, 0, 4'd0, 4'd0, S_RUN);

    set_lu();
    cyc("lu_rs", 0, 0, 32'd0, 1, 1, 0, 1, 0, 4'd0, 4'd0, S_RUN);
    cyc("after_lu", 0, 0, 32'd0, 0, 0, 0, 0, 0, 4'd1, 4'd0, S_RUN);
    ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
    cyc("lu_r0", 0, 0, 32'd0, 0, 0, 0, 0, 0, 4'd1, 4'd0, S_RUN);
    ex_memread = 1'b1; ex_rt = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1; id_rs = 5'd9;
    cyc("lu_rt", 0, 0, 32'd0, 1, 1, 0, 1, 0, 4'd1, 4'd0, S_RUN);
    set_lu(); id_uses_rs = 1'b0;
    cyc("lu_unused", 0, 0, 32'd0, 0, 0, 0, 0, 0, 4'd2, 4'd0, S_RUN);

    set_lu(); halt_req = 1'b1; ex_branch_taken = 1'b1; ex_target = 32'h40;
    cyc("br_prio", 0, 1, 32'h40, 0, 0, 1, 1, 0, 4'd2, 4'd0, S_RUN);
    cyc("after_br", 0, 0, 32'd0, 0, 0, 0, 0, 0, 4'd2, 4'd1, S_RUN);

    imem_ready = 1'b0;
    cyc("wait_enter", 0, 0, 32'd0, 1, 0, 1, 0, 0, 4'd2, 4'd1, S_RUN);
    imem_ready = 1'b0; ex_branch_taken = 1'b1; ex_target = 32'h80;
    cyc("wait_br", 0, 0, 32'd0, 1, 0, 1, 1, 0, 4'd2, 4'd1, S_MW);
    imem_ready = 1'b0;
    cyc("wait3", 0, 0, 32'd0, 1, 0, 1, 0, 0, 4'd3, 4'd1, S_MW);
    imem_ready = 1'b0;
    cyc("wait4", 0, 0, 32'd0, 1, 0, 1, 0, 0, 4'd4, 4'd1, S_MW);
    cyc("deferred", 0, 1, 32'h80, 0, 0, 1, 0, 0, 4'd5, 4'd1, S_MW);
    cyc("after_def", 0, 0, 32'd0, 0, 0, 0, 0, 0, 4'd6, 4'd2, S_RUN);

    imem_ready = 1'b0;
    cyc("wait_enter2", 0, 0, 32'd0, 1, 0, 1, 0, 0, 4'd6, 4'd2, S_RUN);
    imem_ready = 1'b0; set_lu();
    cyc("wait_lu", 0, 0, 32'd0, 1, 1, 0, 1, 0, 4'd6, 4'd2, S_MW);
    ex_branch_taken = 1'b1; ex_target = 32'h100;
    cyc("direct_br", 0, 1, 32'h100, 0, 0, 1, 1, 0, 4'd7, 4'd2, S_MW);
    cyc("after_direct", 0, 0, 32'd0, 0, 0, 0, 0, 0, 4'd8, 4'd3, S_RUN);

    halt_req = 1'b1;
    cyc("halt_req", 0, 0, 32'd0, 1, 1, 0, 1, 0, 4'd8, 4'd3, S_RUN);
    for (int i = 0; i < 10; i++) begin
      ex_branch_taken = i[0]; ex_target = 32'h200; imem_ready = i[1];
      cyc("halt_hold", 0, 0, 32'd0, 1, 1, 0, 1, 1, 4'd8, 4'd3, S_HALT);
    end
    reset = 1'b0;
    boot_cyc("halt_reset");
    boot_cyc("reboot1");
    boot_cyc("reboot2");
    cyc("rerun", 0, 0, 32'd0, 0, 0, 0, 0, 0, 4'd0, 4'd0, S_RUN);

    imem_ready = 1'b0;
    cyc("p_enter", 0, 0, 32'd0, 1, 0, 1, 0, 0, 4'd0, 4'd0, S_RUN);
    imem_ready = 1'b0; ex_branch_taken = 1'b1; ex_target = 32'h80;
    cyc("p_latch", 0, 0, 32'd0, 1, 0, 1, 1, 0, 4'd0, 4'd0, S_MW);
    reset = 1'b0; imem_ready = 1'b0;
    boot_cyc("p_reset");
    boot_cyc("p_boot1");
    boot_cyc("p_boot2");
    imem_ready = 1'b0;
    cyc("p_enter2", 0, 0, 32'd0, 1, 0, 1, 0, 0, 4'd0, 4'd0, S_RUN);
    cyc("p_discard", 0, 0, 32'd0, 0, 0, 0, 0, 0, 4'd0, 4'd0, S_MW);

    sc_exp = 1;
    for (int k = 0; k < 20; k++) begin
      set_lu();
      cyc("sat_lu", 0, 0, 32'd0, 1, 1, 0, 1, 0, 4'(sc_exp), 4'd0, S_RUN);
      if (sc_exp != 15) sc_exp++;
    end
    cyc("sat_final", 0, 0, 32'd0, 0, 0, 0, 0, 0, 4'd15, 4'd0, S_RUN);

    repeat (2) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
